// File: rtl/nat1_mem_tester.sv
// Built-in self-test master for a single-port 1-cycle-latency memory: fills it with a
// pattern, reads it back, compares each word and reports pass/fail with error details.
module nat1_mem_tester #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern_sel,
  input  logic [7:0]        seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [10:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  // state   | meaning
  // S_IDLE  | bus quiet; start latches config, then one launch cycle before FILL
  // S_FILL  | write pattern(addr) to every word
  // S_VERIFY| read every word, compare previous cycle's read data
  // S_DRAIN | compare the final word, bus quiet
  // S_DONE  | one-cycle done pulse, pass valid
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [10:0]       ERR_MAX   = '1;

  state_t              state_q;
  logic                launch_q;
  logic [1:0]          sel_q;
  logic [7:0]          seed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          lfsr_q;
  logic [DATA_W-1:0]   pat_q;
  logic                cs_q, wr_q, busy_q, done_q, pass_q;
  logic [DATA_W-1:0]   wd_q;
  logic [10:0]         err_q;
  logic [ADDR_W-1:0]   fea_q;
  logic                chk_v_q;
  logic [DATA_W-1:0]   chk_exp_q;
  logic [ADDR_W-1:0]   chk_addr_q;

  logic [ADDR_W-1:0]   addr_d;
  logic [7:0]          lfsr_d;
  logic [7:0]          seed_eff;
  logic [DATA_W-1:0]   pat_d;
  logic [DATA_W-1:0]   pat_first;
  logic                mismatch;
  logic [10:0]         err_d;
  logic                active;

  function automatic logic [DATA_W-1:0] pattern_f(input logic [1:0] sel, input logic [7:0] sd,
                                                  input logic [7:0] a8, input logic [7:0] l);
    case (sel)
      2'd0:    return a8;
      2'd1:    return ~a8;
      2'd2:    return sd;
      default: return l;
    endcase
  endfunction

  assign addr_d    = addr_q + ADDR_W'(1);
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign seed_eff  = (seed_q == 8'h00) ? 8'h01 : seed_q;
  assign pat_d     = pattern_f(sel_q, seed_q, addr_d[7:0], lfsr_d);
  assign pat_first = pattern_f(sel_q, seed_q, 8'h00, seed_eff);
  assign active    = (state_q == S_FILL) || (state_q == S_VERIFY) || (state_q == S_DRAIN);
  assign mismatch  = chk_v_q && (m_readdata != chk_exp_q) &&
                     ((state_q == S_VERIFY) || (state_q == S_DRAIN));
  assign err_d     = (mismatch && (err_q != ERR_MAX)) ? err_q + 11'd1 : err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      launch_q   <= 1'b0;
      sel_q      <= 2'd0;
      seed_q     <= 8'h00;
      addr_q     <= '0;
      lfsr_q     <= 8'h00;
      pat_q      <= '0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fea_q      <= '0;
      chk_v_q    <= 1'b0;
      chk_exp_q  <= '0;
      chk_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (active && abort) begin
        // abort wins over any phase transition; error results stay partial
        state_q <= S_IDLE;
        addr_q  <= '0;
        cs_q    <= 1'b0;
        wr_q    <= 1'b0;
        wd_q    <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
        chk_v_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (launch_q) begin
              launch_q <= 1'b0;
              state_q  <= S_FILL;
              addr_q   <= '0;
              lfsr_q   <= seed_eff;
              pat_q    <= pat_first;
              cs_q     <= 1'b1;
              wr_q     <= 1'b1;
              wd_q     <= pat_first;
              busy_q   <= 1'b1;
            end else if (start) begin
              sel_q    <= pattern_sel;
              seed_q   <= seed;
              err_q    <= '0;
              fea_q    <= '0;
              pass_q   <= 1'b0;
              launch_q <= 1'b1;
            end
          end
          S_FILL: begin
            if (addr_q == LAST_ADDR) begin
              state_q <= S_VERIFY;
              addr_q  <= '0;
              lfsr_q  <= seed_eff;
              pat_q   <= pat_first;
              wr_q    <= 1'b0;
              wd_q    <= '0;
              chk_v_q <= 1'b0;
            end else begin
              addr_q <= addr_d;
              lfsr_q <= lfsr_d;
              pat_q  <= pat_d;
              wd_q   <= pat_d;
            end
          end
          S_VERIFY: begin
            err_q <= err_d;
            if (mismatch && (err_q == '0)) fea_q <= chk_addr_q;
            chk_v_q    <= 1'b1;
            chk_exp_q  <= pat_q;
            chk_addr_q <= addr_q;
            if (addr_q == LAST_ADDR) begin
              state_q <= S_DRAIN;
              addr_q  <= '0;
              cs_q    <= 1'b0;
            end else begin
              addr_q <= addr_d;
              lfsr_q <= lfsr_d;
              pat_q  <= pat_d;
            end
          end
          S_DRAIN: begin
            err_q <= err_d;
            if (mismatch && (err_q == '0)) fea_q <= chk_addr_q;
            pass_q  <= (err_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            chk_v_q <= 1'b0;
            state_q <= S_DONE;
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign m_address      = addr_q;
  assign m_chipselect   = cs_q;
  assign m_write        = wr_q;
  assign m_writedata    = wd_q;
  assign m_clken        = busy_q;

endmodule

// File: tb/tb_nat1_mem_tester.sv
// Directed bench for nat1_mem_tester: memory model with injectable read faults,
// table of pattern/fault vectors, plus abort and reset sequences.
module tb_nat1_mem_tester;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [7:0]  seed = 8'h00;
  logic        busy, done, pass;
  logic [10:0] err_count;
  logic [9:0]  first_err_addr, m_address;
  logic        m_chipselect, m_write, m_clken;
  logic [7:0]  m_writedata;
  logic [7:0]  m_readdata;

  always #5 clk = ~clk;

  nat1_mem_tester #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
    .m_clken(m_clken), .m_readdata(m_readdata)
  );

  // memory: 0 clean, 1 bit0 stuck-at-1 at 0x155, 2 every read returns 0xFF
  logic [7:0] mem [0:1023];
  logic [7:0] rd_q = 8'h00;
  int         mem_mode = 0;
  assign m_readdata = rd_q;

  always @(posedge clk) begin
    if (m_chipselect && m_clken) begin
      if (m_write) mem[m_address] <= m_writedata;
      else if (mem_mode == 2) rd_q <= 8'hFF;
      else if (mem_mode == 1 && m_address == 10'h155) rd_q <= mem[m_address] | 8'h01;
      else rd_q <= mem[m_address];
    end
  end

  logic [9:0] wr_a [0:1023];
  logic [7:0] wr_d [0:1023];
  int         wr_n = 0;

  always @(negedge clk) begin
    if (m_chipselect && m_write) begin
      if (wr_n < 1024) begin
        wr_a[wr_n] = m_address;
        wr_d[wr_n] = m_writedata;
      end
      wr_n++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic run_test(input logic [1:0] sel, input logic [7:0] sd, input int glitch,
                          output int done_cyc, output int first_w);
    repeat (3) @(negedge clk);
    wr_n = 0;
    pattern_sel = sel;
    seed = sd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pattern_sel = ~sel;
    seed = ~sd;
    done_cyc = -1;
    first_w = -1;
    for (int c = 1; c <= 2100 && done_cyc < 0; c++) begin
      @(posedge clk);
      #1;
      if (first_w < 0 && m_chipselect && m_write) first_w = c;
      if (done) done_cyc = c;
      start = (c == glitch);
    end
    start = 1'b0;
  endtask

  task automatic check_writes(input string nm, input logic [1:0] sel, input logic [7:0] sd);
    logic [7:0] l;
    logic [7:0] e;
    logic [7:0] a8;
    int bad;
    bad = 0;
    l = (sd == 8'h00) ? 8'h01 : sd;
    check({nm, "_wr_count"}, 32'(wr_n), 32'd1024);
    for (int i = 0; i < 1024; i++) begin
      a8 = i[7:0];
      case (sel)
        2'd0: e = a8;
        2'd1: e = ~a8;
        2'd2: e = sd;
        default: e = l;
      endcase
      if (wr_a[i] !== i[9:0] || wr_d[i] !== e) bad++;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    check({nm, "_wr_bad"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] sd;
    int         mode;
    int         e_err;
    int         e_first;
    int         e_pass;
  } vec_t;

  vec_t vt [7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, fw, found, seen;
    logic [7:0] lf_exp [6];

    vt[0] = '{2'd0, 8'h00, 0, 0,    0,      1};
    vt[1] = '{2'd3, 8'h00, 0, 0,    0,      1};
    vt[2] = '{2'd2, 8'hAA, 1, 1,    'h155,  0};
    vt[3] = '{2'd0, 8'h00, 2, 1020, 0,      0};
    vt[4] = '{2'd3, 8'h5A, 0, 0,    0,      1};
    vt[5] = '{2'd2, 8'hFF, 2, 0,    0,      1};
    vt[6] = '{2'd1, 8'h00, 2, 1020, 1,      0};
    lf_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, pass, err_count, first_err_addr, m_address,
                                m_chipselect, m_write, m_writedata, m_clken}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      mem_mode = vt[k].mode;
      run_test(vt[k].sel, vt[k].sd, -1, dc, fw);
      check($sformatf("v%0d_first_write_cycle", k), 32'(fw), 32'd1);
      check($sformatf("v%0d_done_cycle", k), 32'(dc), 32'd2050);
      check($sformatf("v%0d_err_count", k), 32'(err_count), 32'(vt[k].e_err));
      check($sformatf("v%0d_first_err_addr", k), 32'(first_err_addr), 32'(vt[k].e_first));
      check($sformatf("v%0d_pass", k), 32'(pass), 32'(vt[k].e_pass));
      check_writes($sformatf("v%0d", k), vt[k].sel, vt[k].sd);
      if (k == 1) begin
        for (int j = 0; j < 6; j++)
          check($sformatf("lfsr_write%0d", j), 32'(wr_d[j]), 32'(lf_exp[j]));
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_one_cycle", k), 32'({done, busy}), 32'd0);
      check($sformatf("v%0d_pass_held", k), 32'(pass), 32'(vt[k].e_pass));
    end

    // reset in IDLE clears the previous result
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("idle_reset_result", 32'({pass, err_count, first_err_addr}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // abort in VERIFY at address 100
    mem_mode = 0;
    repeat (3) @(negedge clk);
    pattern_sel = 2'd0;
    seed = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (m_chipselect && !m_write && m_address == 10'd100) found = 1;
    end
    check("abort_reach_addr100", 32'(found), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_idle", 32'({busy, m_chipselect, m_write, m_clken, done, pass}), 32'd0);
    check("abort_err_partial", 32'(err_count), 32'd0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_test(2'd0, 8'h00, -1, dc, fw);
    check("after_abort_done_cycle", 32'(dc), 32'd2050);
    check("after_abort_pass", 32'(pass), 32'd1);

    // asynchronous reset in FILL at address 500
    repeat (3) @(negedge clk);
    pattern_sel = 2'd1;
    seed = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (m_chipselect && m_write && m_address == 10'd500) found = 1;
    end
    check("reset_reach_addr500", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({busy, done, pass, err_count, first_err_addr, m_address,
                                      m_chipselect, m_write, m_writedata, m_clken}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (busy || m_chipselect) seen++;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);
    run_test(2'd3, 8'hC3, 300, dc, fw);
    check("post_reset_done_cycle", 32'(dc), 32'd2050);
    check("post_reset_pass", 32'(pass), 32'd1);
    check_writes("post_reset", 2'd3, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nat1_mem_tester.md
# nat1_mem_tester

Avalon-MM master that exercises a single-port on-chip memory slave (1024 × 8, fixed read latency 1, no waitrequest). It fills every word with a selectable pattern, reads everything back, and compares each word against the regenerated pattern. It reports pass/fail, a saturating error count and the first failing address. It sits beside the memory in the nat1 system as a built-in self-test initiator, and its master port connects directly to the memory's s1 inputs.

## Interface
Parameters:
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, data width; the pattern logic is defined for 8 bits only.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE; a high sample launches a test.
- abort  in  1  sampled in FILL/VERIFY/DRAIN; returns the block to IDLE on the next edge.
- pattern_sel  in  2  0 = addr[7:0], 1 = ~addr[7:0], 2 = seed, 3 = LFSR from seed; latched at start.
- seed  in  8  pattern seed; latched at start.
- busy  out  1  high in FILL, VERIFY and DRAIN.
- done  out  1  one-cycle pulse in the DONE state.
- pass  out  1  valid from the done pulse until the next start; 1 if err_count == 0.
- err_count  out  11  number of mismatches; saturates at 2047.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if there is none.
- m_address  out  ADDR_W  memory address.
- m_chipselect  out  1  memory chipselect.
- m_write  out  1  write strobe.
- m_writedata  out  DATA_W  write data.
- m_clken  out  1  memory clock enable; equals busy.
- m_readdata  in  DATA_W  memory read data; valid 1 cycle after its address is presented.

## Operation
- States: IDLE → FILL → VERIFY → DRAIN → DONE → IDLE.
- IDLE:
  - All master outputs are 0.
  - A high start sample latches pattern_sel and seed, clears err_count, first_err_addr and pass, and enters FILL.
- FILL:
  - m_chipselect = 1 and m_write = 1.
  - m_address steps 0..DEPTH-1, one word per cycle.
  - m_writedata = pattern(addr).
  - After address DEPTH-1 the block enters VERIFY.
- VERIFY:
  - m_chipselect = 1 and m_write = 0.
  - m_address steps 0..DEPTH-1.
  - The expected data and the address go into a 1-stage pipeline register.
  - Each cycle, m_readdata is compared with the previous cycle's expected value.
  - After address DEPTH-1 the block enters DRAIN.
- DRAIN:
  - Chipselect is 0.
  - Compares the last word (address DEPTH-1).
  - Enters DONE.
- DONE: done = 1 for one cycle; pass = (err_count == 0), including the final compare; then IDLE.
- Mismatch handling:
  - err_count increments and saturates at 2047.
  - On the first mismatch, first_err_addr captures the pipelined address.
- Pattern 3 (LFSR):
  - 8-bit Fibonacci LFSR, next = {l[6:0], l[7]^l[5]^l[4]^l[3]}.
  - Loaded with seed, or with 0x01 when seed == 0.
  - Advances once per address.
  - Reloaded from the latched seed at VERIFY entry, so the same sequence regenerates for the read-back.
- Address and pattern counters wrap cleanly from DEPTH-1 at each phase boundary; no extra access is issued.
- start while busy is ignored; start held high through DONE launches a new test from IDLE.
- abort:
  - Next edge goes to IDLE with chipselect 0.
  - No done pulse; pass = 0.
  - err_count and first_err_addr keep their partial values.
  - abort has priority over any same-edge state transition.

## Timing
- Reset (reset_n low, asynchronous) forces state IDLE and all outputs 0, including pass, err_count and first_err_addr. This holds even mid-operation.
- The start sample at edge E0 puts address 0 on the bus in cycle 1, after E1.
- The FILL, VERIFY, DRAIN and DONE phases occupy these cycles:
  - FILL: cycles 1..DEPTH.
  - VERIFY: cycles DEPTH+1..2·DEPTH.
  - DRAIN: cycle 2·DEPTH+1.
  - DONE: cycle 2·DEPTH+2, which is 2050 for the default parameters.
- Read compare latency is exactly 1 cycle; the block has no waitrequest support.
- The first write of a test follows a previous DONE by 2 cycles or more (DONE → IDLE → FILL).

## Test plan
- Clean memory model, pattern 0 → writes 0x00..0xFF repeating; done pulses in cycle 2050; pass = 1, err_count = 0, first_err_addr = 0.
- Pattern 3, seed 0x00 → first writes are 0x01, 0x02, 0x04, 0x08, 0x11, 0x23; VERIFY reproduces the same sequence; pass = 1.
- Memory model with bit 0 stuck-at-1 at address 0x155, pattern 2, seed 0xAA → err_count = 1, first_err_addr = 0x155, pass = 0.
- Memory model returning 0xFF for every read, pattern 0 → err_count = 1020, first_err_addr = 0x000, pass = 0. There are only 4 matches: 0x0FF, 0x1FF, 0x2FF, 0x3FF.
- abort asserted while m_address = 100 in VERIFY → IDLE next cycle, chipselect 0, no done pulse, pass = 0. A following start runs a full test to pass = 1.
- reset_n pulsed low in FILL at address 500 → all outputs 0 immediately; start pulsed during busy has no effect; a post-reset start completes normally.
